// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package riscv_mem_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic {IDLE, BUSY} state_e;
   typedef enum logic {OWN_I, OWN_D} owner_e;

   // Size 3 is never legal, halves need bit 0 clear, words need both low bits clear.
   function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (size)
         SIZE_B:  mis = 1'b0;
         SIZE_H:  mis = off[0];
         SIZE_W:  mis = |off;
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Fetch, load/store, memory-macro and error signals of the memory arbiter.
interface riscv_mem_arbiter_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_en;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        error_instrmem_misaligned_access;
   logic        error_instrmem_invalid_address;
   logic        error_datamem_misaligned_access;
   logic        error_datamem_invalid_address;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output error_instrmem_misaligned_access, error_instrmem_invalid_address,
      output error_datamem_misaligned_access, error_datamem_invalid_address
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  error_instrmem_misaligned_access, error_instrmem_invalid_address,
      input  error_datamem_misaligned_access, error_datamem_invalid_address
   );

endinterface

// File: rtl/riscv_mem_align.sv
// Byte-lane steering: write enables/replication on requests, extraction on responses.
module riscv_mem_align
   import riscv_mem_pkg::*;
(
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [1:0]  req_off,
   input  logic [31:0] req_wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [1:0]  rsp_size,
   input  logic [1:0]  rsp_off,
   input  logic [31:0] rsp_rdata,
   output logic [31:0] rdata
);

   // Loads and fetches always read the full word; only stores narrow the lanes.
   always_comb begin
      be    = 4'b1111;
      wdata = req_wdata;
      if (req_we) begin
         case (req_size)
            SIZE_B: begin
               be    = 4'b0001 << req_off;
               wdata = {4{req_wdata[7:0]}};
            end
            SIZE_H: begin
               be    = req_off[1] ? 4'b1100 : 4'b0011;
               wdata = {2{req_wdata[15:0]}};
            end
            default: begin
               be    = 4'b1111;
               wdata = req_wdata;
            end
         endcase
      end
   end

   always_comb begin
      rdata = rsp_rdata;
      case (rsp_size)
         SIZE_B: begin
            case (rsp_off)
               2'd0:    rdata = {24'd0, rsp_rdata[7:0]};
               2'd1:    rdata = {24'd0, rsp_rdata[15:8]};
               2'd2:    rdata = {24'd0, rsp_rdata[23:16]};
               default: rdata = {24'd0, rsp_rdata[31:24]};
            endcase
         end
         SIZE_H:  rdata = {16'd0, rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0]};
         default: rdata = rsp_rdata;
      endcase
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store,
// one outstanding access at a time over a fixed latency.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int MEM_DEPTH_WORDS = 1024,
   parameter int MEM_LATENCY     = 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   riscv_mem_arbiter_if.slave   bus
);

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_DEPTH_WORDS) << 2;
   localparam logic [2:0]  LAT        = 3'(MEM_LATENCY);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   owner_e      last_q, owner_q;
   logic        we_q, err_q;
   logic [1:0]  size_q, off_q;

   logic        last_cycle, can_grant, d_win, gnt_i, gnt_d, gnt_any;
   logic        i_mis, i_inv, d_mis, d_inv, req_err;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;

   assign last_cycle = (state_q == BUSY) && (cnt_q == 3'd1);
   // Grants are held off while reset is asserted so every output reads 0.
   assign can_grant  = rstn && ((state_q == IDLE) || last_cycle);
   assign d_win      = bus.d_req && (!bus.i_req || (last_q == OWN_I));
   assign gnt_d      = can_grant && d_win;
   assign gnt_i      = can_grant && bus.i_req && !d_win;
   assign gnt_any    = gnt_i || gnt_d;

   assign i_mis   = |bus.i_addr[1:0];
   assign i_inv   = {1'b0, bus.i_addr} >= ADDR_LIMIT;
   assign d_mis   = size_misaligned(bus.d_size, bus.d_addr[1:0]);
   assign d_inv   = {1'b0, bus.d_addr} >= ADDR_LIMIT;
   assign req_err = gnt_d ? (d_mis || d_inv) : (i_mis || i_inv);

   riscv_mem_align u_align (
      .req_we    (gnt_d && bus.d_we),
      .req_size  (gnt_d ? bus.d_size : SIZE_W),
      .req_off   (bus.d_addr[1:0]),
      .req_wdata (bus.d_wdata),
      .be        (al_be),
      .wdata     (al_wdata),
      .rsp_size  (size_q),
      .rsp_off   (off_q),
      .rsp_rdata (bus.mem_rdata),
      .rdata     (al_rdata)
   );

   // Erroneous requests are granted but never reach the macro.
   assign bus.i_gnt     = gnt_i;
   assign bus.d_gnt     = gnt_d;
   assign bus.mem_en    = gnt_any && !req_err;
   assign bus.mem_we    = bus.mem_en && gnt_d && bus.d_we;
   assign bus.mem_be    = bus.mem_en ? al_be : 4'b0000;
   assign bus.mem_addr  = !bus.mem_en ? 30'd0 : (gnt_d ? bus.d_addr[31:2] : bus.i_addr[31:2]);
   assign bus.mem_wdata = bus.mem_we ? al_wdata : 32'd0;

   assign bus.error_instrmem_misaligned_access = gnt_i && i_mis;
   assign bus.error_instrmem_invalid_address   = gnt_i && i_inv;
   assign bus.error_datamem_misaligned_access  = gnt_d && d_mis;
   assign bus.error_datamem_invalid_address    = gnt_d && d_inv;

   assign bus.i_rvalid = last_cycle && (owner_q == OWN_I);
   assign bus.d_rvalid = last_cycle && (owner_q == OWN_D);
   assign bus.i_rdata  = (bus.i_rvalid && !err_q) ? bus.mem_rdata : 32'd0;
   assign bus.d_rdata  = (bus.d_rvalid && !err_q && !we_q) ? al_rdata : 32'd0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d = BUSY;
               cnt_d   = LAT;
            end
         end
         BUSY: begin
            if (last_cycle) begin
               if (gnt_any) begin
                  cnt_d = LAT;
               end else begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         last_q  <= OWN_I;
         owner_q <= OWN_I;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= SIZE_W;
         off_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (gnt_any) begin
            last_q  <= gnt_d ? OWN_D : OWN_I;
            owner_q <= gnt_d ? OWN_D : OWN_I;
            we_q    <= gnt_d && bus.d_we;
            err_q   <= req_err;
            size_q  <= gnt_d ? bus.d_size : SIZE_W;
            off_q   <= gnt_d ? bus.d_addr[1:0] : 2'd0;
         end
      end
   end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with MEM_LATENCY = 2, MEM_DEPTH_WORDS = 1024.
module tb_riscv_mem_arbiter;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   riscv_mem_arbiter_if bus();

   riscv_mem_arbiter #(.MEM_DEPTH_WORDS(1024), .MEM_LATENCY(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   wire [3:0] errs = {bus.error_instrmem_misaligned_access, bus.error_instrmem_invalid_address,
                      bus.error_datamem_misaligned_access, bus.error_datamem_invalid_address};
   wire [140:0] all_out = {bus.i_gnt, bus.i_rvalid, bus.i_rdata, bus.d_gnt, bus.d_rvalid,
                           bus.d_rdata, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr,
                           bus.mem_wdata, errs};

   task automatic clear_inputs();
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = '0; bus.d_wdata = '0;
      bus.mem_rdata = '0;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      clear_inputs();
      rstn = 1'b0;
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      repeat (2) tick();
      #1;
      checks++;
      if (all_out !== '0) begin
         failures++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      tick(); rstn = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.mem_rdata = 32'h00500093;
      #1;
      checks++;
      if ({bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be} !== 8'b1010_1111) begin
         failures++; $display("FAIL fetch_grant: got %b want 10101111",
                              {bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be});
      end
      checks++;
      if (bus.mem_addr !== 30'h4) begin
         failures++; $display("FAIL fetch_addr: got %h want 4", bus.mem_addr);
      end
      tick(); bus.i_req = 1'b0; #1;
      checks++;
      if ({bus.i_gnt, bus.i_rvalid} !== 2'b00) begin
         failures++; $display("FAIL fetch_t1: got %b want 00", {bus.i_gnt, bus.i_rvalid});
      end
      tick(); #1;
      checks++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata} !== {2'b10, 32'h00500093}) begin
         failures++; $display("FAIL fetch_rvalid: got %b %b %h want 1 0 00500093",
                              bus.i_rvalid, bus.d_rvalid, bus.i_rdata);
      end
      tick(); #1;
      checks++;
      if (bus.i_rvalid !== 1'b0) begin
         failures++; $display("FAIL fetch_pulse: got %b want 0", bus.i_rvalid);
      end
      tick();
   endtask

   task automatic test_conflict();
      logic exp_ig, exp_dg, exp_ir, exp_dr;
      test_reset();
      bus.i_req = 1'b1; bus.i_addr = 32'h40;
      bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_size = 2'd2;
      bus.mem_rdata = 32'h1234_5678;
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_dg = (k % 4 == 0);
         exp_ig = (k % 4 == 2);
         exp_dr = (k == 2) || (k == 6);
         exp_ir = (k == 4);
         checks++;
         if ({bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid} !== {exp_dg, exp_ig, exp_dr, exp_ir}) begin
            failures++; $display("FAIL conflict_cycle%0d: got dg/ig/dr/ir %b want %b", k,
                                 {bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid},
                                 {exp_dg, exp_ig, exp_dr, exp_ir});
         end
         tick();
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      #1;
      checks++;
      if ({bus.i_rvalid, bus.d_rvalid} !== 2'b10) begin
         failures++; $display("FAIL conflict_last_rvalid: got %b want 10", {bus.i_rvalid, bus.d_rvalid});
      end
      repeat (2) tick();
   endtask

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] mwdata;
      logic [31:0] dout;
   } lane_vec_t;

   task automatic test_lanes();
      lane_vec_t v [6];
      v[0] = '{1'b1, 2'd0, 32'h103, 32'h0000_00AB, 32'h5555_5555, 4'b1000, 32'hABAB_ABAB, 32'h0};
      v[1] = '{1'b0, 2'd1, 32'h102, 32'h0,         32'hBEEF_1234, 4'b1111, 32'h0,         32'h0000_BEEF};
      v[2] = '{1'b0, 2'd0, 32'h101, 32'h0,         32'hBEEF_1234, 4'b1111, 32'h0,         32'h0000_0012};
      v[3] = '{1'b1, 2'd1, 32'h102, 32'h0000_5678, 32'h0,         4'b1100, 32'h5678_5678, 32'h0};
      v[4] = '{1'b1, 2'd2, 32'h200, 32'h1122_3344, 32'hFFFF_FFFF, 4'b1111, 32'h1122_3344, 32'h0};
      v[5] = '{1'b0, 2'd2, 32'h204, 32'h9999_9999, 32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D};
      for (int n = 0; n < 6; n++) begin
         bus.d_req = 1'b1; bus.d_we = v[n].we; bus.d_size = v[n].size;
         bus.d_addr = v[n].addr; bus.d_wdata = v[n].wdata; bus.mem_rdata = v[n].rdata;
         #1;
         checks++;
         if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !==
             {2'b11, v[n].we, v[n].be, v[n].addr[31:2], v[n].mwdata}) begin
            failures++; $display("FAIL lane_req%0d: got we=%b be=%b addr=%h wdata=%h want we=%b be=%b addr=%h wdata=%h",
                                 n, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                                 v[n].we, v[n].be, v[n].addr[31:2], v[n].mwdata);
         end
         tick(); bus.d_req = 1'b0;
         tick(); #1;
         checks++;
         if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, v[n].dout}) begin
            failures++; $display("FAIL lane_rsp%0d: got %b %h want 1 %h", n, bus.d_rvalid, bus.d_rdata, v[n].dout);
         end
         tick();
      end
      clear_inputs();
   endtask

   typedef struct packed {
      logic        is_d;
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  err;
      logic [31:0] dout;
   } err_vec_t;

   task automatic test_errors();
      err_vec_t v [7];
      logic exp_en;
      v[0] = '{1'b1, 1'b0, 2'd2, 32'h6,    4'b0010, 32'h0};
      v[1] = '{1'b0, 1'b0, 2'd2, 32'h1000, 4'b0100, 32'h0};
      v[2] = '{1'b0, 1'b0, 2'd2, 32'hFFC,  4'b0000, 32'hDEAD_BEEF};
      v[3] = '{1'b0, 1'b0, 2'd2, 32'h1002, 4'b1100, 32'h0};
      v[4] = '{1'b1, 1'b1, 2'd0, 32'h1000, 4'b0001, 32'h0};
      v[5] = '{1'b1, 1'b0, 2'd3, 32'h0,    4'b0010, 32'h0};
      v[6] = '{1'b1, 1'b0, 2'd1, 32'hFFE,  4'b0000, 32'h0000_DEAD};
      bus.mem_rdata = 32'hDEAD_BEEF;
      for (int n = 0; n < 7; n++) begin
         exp_en = (v[n].err == 4'b0000);
         if (v[n].is_d) begin
            bus.d_req = 1'b1; bus.d_we = v[n].we; bus.d_size = v[n].size;
            bus.d_addr = v[n].addr; bus.d_wdata = 32'h77;
         end else begin
            bus.i_req = 1'b1; bus.i_addr = v[n].addr;
         end
         #1;
         checks++;
         if ({bus.i_gnt, bus.d_gnt, bus.mem_en, errs} !== {!v[n].is_d, v[n].is_d, exp_en, v[n].err}) begin
            failures++; $display("FAIL err_req%0d: got ig/dg/en/err %b want %b", n,
                                 {bus.i_gnt, bus.d_gnt, bus.mem_en, errs},
                                 {!v[n].is_d, v[n].is_d, exp_en, v[n].err});
         end
         tick(); bus.i_req = 1'b0; bus.d_req = 1'b0; #1;
         checks++;
         if (errs !== 4'b0000) begin
            failures++; $display("FAIL err_pulse%0d: got %b want 0000", n, errs);
         end
         tick(); #1;
         checks++;
         if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata | bus.d_rdata} !== {!v[n].is_d, v[n].is_d, v[n].dout}) begin
            failures++; $display("FAIL err_rsp%0d: got %b %b %h want %b %b %h", n, bus.i_rvalid, bus.d_rvalid,
                                 bus.i_rdata | bus.d_rdata, !v[n].is_d, v[n].is_d, v[n].dout);
         end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      bus.d_req = 1'b1; bus.d_addr = 32'h20; bus.d_size = 2'd2; bus.mem_rdata = 32'hA5A5_A5A5;
      #1;
      checks++;
      if (bus.d_gnt !== 1'b1) begin
         failures++; $display("FAIL mid_grant: got %b want 1", bus.d_gnt);
      end
      tick();
      bus.i_req = 1'b1; rstn = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         failures++; $display("FAIL mid_reset_outputs: got %h want 0", all_out);
      end
      tick(); bus.i_req = 1'b0; bus.d_req = 1'b0; rstn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
            failures++; $display("FAIL mid_stray_rvalid%0d: got %b want 00", k, {bus.i_rvalid, bus.d_rvalid});
         end
         tick();
      end
      bus.i_req = 1'b1; bus.d_req = 1'b1;
      #1;
      checks++;
      if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
         failures++; $display("FAIL mid_first_conflict: got dg/ig %b want 10", {bus.d_gnt, bus.i_gnt});
      end
      tick(); clear_inputs();
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_conflict();
      test_lanes();
      test_errors();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
